// File: rtl/angle_peak_finder_if.sv
// Beam-power input stream and peak-angle result bundle for angle_peak_finder.
// The master side feeds powers and reads results; the slave side is the peak finder itself.
interface angle_peak_finder_if #(
  parameter int PWR_W = 24
);
  logic                    sweep_start;
  logic                    pwr_valid;
  logic        [PWR_W-1:0] pwr;
  logic                    busy;
  logic                    wbdone;
  logic signed [7:0]       angle;
  logic        [PWR_W-1:0] peak_pwr;
  logic                    overrun;

  modport master (
    output sweep_start, pwr_valid, pwr,
    input  busy, wbdone, angle, peak_pwr, overrun
  );

  modport slave (
    input  sweep_start, pwr_valid, pwr,
    output busy, wbdone, angle, peak_pwr, overrun
  );
endinterface

// File: rtl/angle_peak_finder.sv
// Scans one sweep of beam powers and reports the signed angle of the strongest beam,
// with a single-cycle wbdone pulse when the result registers update.
module angle_peak_finder #(
  parameter int NUM_BEAMS = 37,
  parameter int ANG_MIN   = -90,
  parameter int ANG_STEP  = 5,
  parameter int PWR_W     = 24
) (
  input logic                clk,
  input logic                reset,
  angle_peak_finder_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_BEAMS + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_BEAMS - 1);
  localparam logic [7:0] AngMin8  = 8'(ANG_MIN);
  localparam logic [7:0] AngStep8 = 8'(ANG_STEP);

  typedef enum logic {StIdle, StScan} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         run_ang_q, run_ang_d;
  logic [PWR_W-1:0]   best_pwr_q, best_pwr_d;
  logic [7:0]         best_ang_q, best_ang_d;
  logic [7:0]         angle_q, angle_d;
  logic [PWR_W-1:0]   peak_q, peak_d;
  logic               overrun_q, overrun_d;
  logic               wbdone_q, wbdone_d;

  logic [IDX_W-1:0]   cur_idx;
  logic [7:0]         cur_ang;
  logic [PWR_W-1:0]   cur_best_pwr;
  logic [7:0]         cur_best_ang;
  logic               take;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_ang_d    = run_ang_q;
    best_pwr_d   = best_pwr_q;
    best_ang_d   = best_ang_q;
    angle_d      = angle_q;
    peak_d       = peak_q;
    overrun_d    = overrun_q;
    wbdone_d     = 1'b0;
    cur_idx      = idx_q;
    cur_ang      = run_ang_q;
    cur_best_pwr = best_pwr_q;
    cur_best_ang = best_ang_q;
    take         = 1'b0;

    // A start (idle or mid-sweep) rewinds the scan; a coincident sample becomes beam 0.
    if (bus.sweep_start) begin
      state_d      = StScan;
      overrun_d    = 1'b0;
      cur_idx      = '0;
      cur_ang      = AngMin8;
      cur_best_pwr = '0;
      cur_best_ang = '0;
      idx_d        = '0;
      run_ang_d    = AngMin8;
      best_pwr_d   = '0;
      best_ang_d   = '0;
      take         = bus.pwr_valid;
    end else if (state_q == StScan) begin
      take = bus.pwr_valid;
    end else if (bus.pwr_valid) begin
      overrun_d = 1'b1;
    end

    if (take) begin
      // Strict compare keeps the lowest index on ties.
      if ((cur_idx == '0) || (bus.pwr > cur_best_pwr)) begin
        cur_best_pwr = bus.pwr;
        cur_best_ang = cur_ang;
      end
      best_pwr_d = cur_best_pwr;
      best_ang_d = cur_best_ang;
      if (cur_idx == LastIdx) begin
        angle_d   = cur_best_ang;
        peak_d    = cur_best_pwr;
        wbdone_d  = 1'b1;
        state_d   = StIdle;
        idx_d     = '0;
        run_ang_d = AngMin8;
      end else begin
        idx_d     = cur_idx + 1'b1;
        run_ang_d = cur_ang + AngStep8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      run_ang_q  <= '0;
      best_pwr_q <= '0;
      best_ang_q <= '0;
      angle_q    <= '0;
      peak_q     <= '0;
      overrun_q  <= 1'b0;
      wbdone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_ang_q  <= run_ang_d;
      best_pwr_q <= best_pwr_d;
      best_ang_q <= best_ang_d;
      angle_q    <= angle_d;
      peak_q     <= peak_d;
      overrun_q  <= overrun_d;
      wbdone_q   <= wbdone_d;
    end
  end

  assign bus.busy     = (state_q == StScan);
  assign bus.wbdone   = wbdone_q;
  assign bus.angle    = angle_q;
  assign bus.peak_pwr = peak_q;
  assign bus.overrun  = overrun_q;

endmodule
